// File: rtl/hazard_stall_ctrl.sv
// Purpose: hazard detection and stall/flush control for a 5-stage pipeline (load-use, taken branch, MULT/DIV vs MFHI/MFLO).
// Latency: control outputs are combinational (same cycle); the FSM and stall counter update on the rising edge.
// Backpressure: stalls the front end by dropping PCWr/IF_ID_Wr and injecting an ID/EX bubble.
module hazard_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_MdRead,
    input  logic             ID_Ex_MemRead,
    input  logic [4:0]       ID_Ex_Rt,
    input  logic             Branch_Taken,
    input  logic             MD_Start,
    output logic             PCWr,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_Ex_Bubble,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] Stall_Cnt
);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

    localparam logic [3:0] MD_RELOAD = 4'(MD_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       lu, md;

    // $zero is never a real dependence, and rt only matters when ID reads it.
    assign lu = ID_Ex_MemRead && (ID_Ex_Rt != 5'd0) &&
                ((ID_Ex_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_Ex_Rt == IF_ID_Rt)));
    assign md = (state == MD_BUSY) && IF_ID_MdRead;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // A taken branch never cancels an issued MULT/DIV, so it plays no part here.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            RUN: begin
                if (MD_Start) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = MD_RELOAD;
                end
            end
            MD_BUSY: begin
                if (MD_Start) begin
                    md_cnt_nxt = MD_RELOAD;
                end else if (md_cnt == 4'd1) begin
                    state_nxt  = RUN;
                    md_cnt_nxt = 4'd0;
                end else begin
                    md_cnt_nxt = md_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        PCWr         = 1'b1;
        IF_ID_Wr     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_Ex_Bubble = 1'b0;
        MD_Busy      = 1'b0;
        if (!reset) begin
            MD_Busy = (state == MD_BUSY);
            if (Branch_Taken) begin
                IF_ID_Flush  = 1'b1;
                ID_Ex_Bubble = 1'b1;
            end else if (lu || md) begin
                PCWr         = 1'b0;
                IF_ID_Wr     = 1'b0;
                ID_Ex_Bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Stall_Cnt <= '0;
        end else if (!PCWr && (Stall_Cnt != {CNT_W{1'b1}})) begin
            Stall_Cnt <= Stall_Cnt + 1'b1;
        end
    end

endmodule
